// File: rtl/sq_pg_mux.sv
// sq_pg_mux: time-multiplexed phase generator.
// A single adder serves CHANNELS phase accumulators. The channels are visited
// round-robin, one per clock while run is high. Each channel has its own
// frequency configuration, a key-on phase reset and a wrap flag. The result
// for a visited channel appears one cycle after its visit.
module sq_pg_mux #(
  parameter  int CHANNELS = 4,
  parameter  int ACC_W    = 20,
  parameter  int PHASE_W  = 10,
  localparam int CH_W     = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [10:0]         cfg_fnumber,
  input  logic [2:0]          cfg_block,
  input  logic [3:0]          cfg_multiple,
  input  logic [CHANNELS-1:0] key_on,
  output logic [PHASE_W-1:0]  phase,
  output logic [CH_W-1:0]     phase_ch,
  output logic                phase_valid,
  output logic                wrap
);

  localparam int INC_W = 22;

  // Phase increment: fnumber shifted by the octave, then scaled by the
  // multiple. A multiple of 0 stands for one half.
  function automatic logic [INC_W-1:0] calc_inc(input logic [10:0] fnum,
                                                input logic [2:0]  blk,
                                                input logic [3:0]  mult);
    logic [17:0] fmult;
    fmult = 18'(fnum) << blk;
    if (mult == 4'd0) return INC_W'(fmult >> 1);
    else              return INC_W'(fmult) * INC_W'(mult);
  endfunction

  // Modulo accumulate. Only the low ACC_W bits of the increment take part,
  // so the MSB of the result is the carry out of the accumulator.
  function automatic logic [ACC_W:0] add_wrap(input logic [ACC_W-1:0] acc,
                                              input logic [INC_W-1:0] inc);
    return {1'b0, acc} + {1'b0, ACC_W'(inc)};
  endfunction

  // Per-channel state.
  logic [ACC_W-1:0]    acc_q  [CHANNELS];
  logic [10:0]         fnum_q [CHANNELS];
  logic [2:0]          blk_q  [CHANNELS];
  logic [3:0]          mult_q [CHANNELS];
  logic [CHANNELS-1:0] key_q;

  // Slot counter: the channel being visited on the coming edge.
  logic [CH_W-1:0]     slot_p0;
  logic [CH_W-1:0]     slot_nxt_p0;

  // Stage p0: combinational evaluation of the visited channel.
  logic [INC_W-1:0]    inc_p0;
  logic [ACC_W:0]      sum_p0;
  logic                key_rise_p0;
  logic [ACC_W-1:0]    acc_nxt_p0;
  logic                wrap_nxt_p0;
  logic                cfg_ok_p0;

  // Select the visited channel's config and accumulator, form the next value.
  always_comb begin
    inc_p0      = calc_inc(fnum_q[slot_p0], blk_q[slot_p0], mult_q[slot_p0]);
    sum_p0      = add_wrap(acc_q[slot_p0], inc_p0);
    key_rise_p0 = key_on[slot_p0] & ~key_q[slot_p0];
    acc_nxt_p0  = key_rise_p0 ? '0 : sum_p0[ACC_W-1:0];
    wrap_nxt_p0 = key_rise_p0 ? 1'b0 : sum_p0[ACC_W];
    slot_nxt_p0 = (slot_p0 == CH_W'(CHANNELS - 1)) ? '0 : slot_p0 + CH_W'(1);
    cfg_ok_p0   = ({1'b0, cfg_ch} < (CH_W + 1)'(CHANNELS));
  end

  // Stage p0 -> p1: slot advance, key-state sampling and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_p0     <= '0;
      key_q       <= '0;
      phase       <= '0;
      phase_ch    <= '0;
      phase_valid <= 1'b0;
      wrap        <= 1'b0;
    end else if (run) begin
      slot_p0          <= slot_nxt_p0;
      key_q[slot_p0]   <= key_on[slot_p0];
      phase            <= acc_nxt_p0[ACC_W-1 -: PHASE_W];
      phase_ch         <= slot_p0;
      phase_valid      <= 1'b1;
      wrap             <= wrap_nxt_p0;
    end else begin
      phase_valid <= 1'b0;
    end
  end

  // Accumulator write-back for the visited channel only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
    end else if (run) begin
      acc_q[slot_p0] <= acc_nxt_p0;
    end
  end

  // Config registers. A write on the same edge as a visit of that channel is
  // seen from the following visit; out-of-range channel numbers are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        fnum_q[i] <= '0;
        blk_q[i]  <= '0;
        mult_q[i] <= '0;
      end
    end else if (cfg_we && cfg_ok_p0) begin
      fnum_q[cfg_ch] <= cfg_fnumber;
      blk_q[cfg_ch]  <= cfg_block;
      mult_q[cfg_ch] <= cfg_multiple;
    end
  end

endmodule

// File: tb/tb_sq_pg_mux.sv
// Directed bench for sq_pg_mux: a 4-channel instance for the main sequence
// and a 3-channel instance for non-power-of-2 slot wrap and address range.
module tb_sq_pg_mux;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [10:0] cfg_fnumber;
  logic [2:0]  cfg_block;
  logic [3:0]  cfg_multiple;
  logic [3:0]  key_on;
  logic [9:0]  phase;
  logic [1:0]  phase_ch;
  logic        phase_valid;
  logic        wrap;

  logic        run3;
  logic        cfg_we3;
  logic [1:0]  cfg_ch3;
  logic [10:0] cfg_fnumber3;
  logic [2:0]  cfg_block3;
  logic [3:0]  cfg_multiple3;
  logic [2:0]  key_on3;
  logic [9:0]  phase3;
  logic [1:0]  phase_ch3;
  logic        phase_valid3;
  logic        wrap3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sq_pg_mux #(.CHANNELS(4), .ACC_W(20), .PHASE_W(10)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_fnumber(cfg_fnumber), .cfg_block(cfg_block), .cfg_multiple(cfg_multiple),
    .key_on(key_on), .phase(phase), .phase_ch(phase_ch),
    .phase_valid(phase_valid), .wrap(wrap)
  );

  sq_pg_mux #(.CHANNELS(3), .ACC_W(20), .PHASE_W(10)) dut3 (
    .clk(clk), .reset_n(reset_n), .run(run3), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3),
    .cfg_fnumber(cfg_fnumber3), .cfg_block(cfg_block3), .cfg_multiple(cfg_multiple3),
    .key_on(key_on3), .phase(phase3), .phase_ch(phase_ch3),
    .phase_valid(phase_valid3), .wrap(wrap3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic exp_out(input string tag, input int ch, input int ph, input int wr);
    chk({tag, ".ch"},    32'(phase_ch),    32'(ch));
    chk({tag, ".phase"}, 32'(phase),       32'(ph));
    chk({tag, ".wrap"},  32'(wrap),        32'(wr));
    chk({tag, ".valid"}, 32'(phase_valid), 32'd1);
  endtask

  task automatic exp_out3(input string tag, input int ch, input int ph);
    chk({tag, ".ch"},    32'(phase_ch3),    32'(ch));
    chk({tag, ".phase"}, 32'(phase3),       32'(ph));
    chk({tag, ".wrap"},  32'(wrap3),        32'd0);
    chk({tag, ".valid"}, 32'(phase_valid3), 32'd1);
  endtask

  task automatic cfg_write(input int ch, input int fn, input int blk, input int mul);
    cfg_ch = 2'(ch); cfg_fnumber = 11'(fn); cfg_block = 3'(blk); cfg_multiple = 4'(mul);
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_write3(input int ch, input int fn, input int blk, input int mul);
    cfg_ch3 = 2'(ch); cfg_fnumber3 = 11'(fn); cfg_block3 = 3'(blk); cfg_multiple3 = 4'(mul);
    cfg_we3 = 1'b1;
    tick();
    cfg_we3 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_fnumber = '0; cfg_block = '0; cfg_multiple = '0; key_on = '0;
    run3 = 1'b0; cfg_we3 = 1'b0; cfg_ch3 = '0;
    cfg_fnumber3 = '0; cfg_block3 = '0; cfg_multiple3 = '0; key_on3 = '0;
    ticks(2);

    chk("rst.phase", 32'(phase),       32'd0);
    chk("rst.ch",    32'(phase_ch),    32'd0);
    chk("rst.valid", 32'(phase_valid), 32'd0);
    chk("rst.wrap",  32'(wrap),        32'd0);
    chk("rst3.valid", 32'(phase_valid3), 32'd0);
    reset_n = 1'b1;
    tick();

    // ch0 inc 1024, ch1 inc 512 (x0.5), ch2 inc 3930240 -> 784512 mod 2^20
    cfg_write(0, 1024, 0, 1);
    cfg_write(1, 1024, 0, 0);
    cfg_write(2, 2047, 7, 15);
    chk("idle.valid", 32'(phase_valid), 32'd0);

    run = 1'b1;
    tick(); exp_out("r1c0", 0, 1, 0);
    tick(); exp_out("r1c1", 1, 0, 0);
    tick(); exp_out("r1c2", 2, 766, 0);
    tick(); exp_out("r1c3", 3, 0, 0);
    tick(); exp_out("r2c0", 0, 2, 0);
    tick(); exp_out("r2c1", 1, 1, 0);
    tick(); exp_out("r2c2", 2, 508, 1);
    tick(); exp_out("r2c3", 3, 0, 0);
    tick(); exp_out("r3c0", 0, 3, 0);
    tick(); exp_out("r3c1", 1, 1, 0);
    tick(); exp_out("r3c2", 2, 250, 1);
    tick(); exp_out("r3c3", 3, 0, 0);

    // pause: valid drops, outputs and slot hold
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold.valid", 32'(phase_valid), 32'd0);
      chk("hold.ch",    32'(phase_ch),    32'd3);
      chk("hold.phase", 32'(phase),       32'd0);
    end
    run = 1'b1;
    tick(); exp_out("res.c0", 0, 4, 0);
    tick(); exp_out("res.c1", 1, 2, 0);
    tick(); exp_out("res.c2", 2, 1016, 0);
    tick(); exp_out("res.c3", 3, 0, 0);

    // config write on the ch0 visit edge: old inc now, new inc (2048) next
    cfg_write(0, 1024, 1, 1);
    exp_out("col.c0", 0, 5, 0);
    tick(); exp_out("col.c1", 1, 2, 0);
    tick(); exp_out("col.c2", 2, 758, 1);
    tick(); exp_out("col.c3", 3, 0, 0);
    tick(); exp_out("new.c0", 0, 7, 0);

    // key-on resets ch0 at its next visit
    key_on = 4'b0001;
    tick(); exp_out("key.c1", 1, 3, 0);
    tick(); exp_out("key.c2", 2, 500, 1);
    tick(); exp_out("key.c3", 3, 0, 0);
    tick(); exp_out("keyon.c0", 0, 0, 0);
    ticks(4); exp_out("keyhold.c0", 0, 2, 0);
    key_on = 4'b0000;
    ticks(4); exp_out("keyoff.c0", 0, 4, 0);
    key_on = 4'b0001;
    ticks(4); exp_out("rekey.c0", 0, 0, 0);

    // ch0 with inc 2048 wraps after 512 visits
    for (int i = 1; i <= 512; i++) begin
      ticks(4);
      chk("wrapseq.ch",    32'(phase_ch), 32'd0);
      chk("wrapseq.phase", 32'(phase),    32'((i * 2) % 1024));
      chk("wrapseq.wrap",  32'(wrap),     32'(i == 512));
    end

    // async reset mid-run
    tick();
    reset_n = 1'b0;
    #1;
    chk("arst.phase", 32'(phase),       32'd0);
    chk("arst.ch",    32'(phase_ch),    32'd0);
    chk("arst.valid", 32'(phase_valid), 32'd0);
    chk("arst.wrap",  32'(wrap),        32'd0);
    tick();
    reset_n = 1'b1;
    tick(); exp_out("post.c0", 0, 0, 0);
    tick(); exp_out("post.c1", 1, 0, 0);

    // 3-channel instance: cfg_ch=3 is out of range and ignored
    run = 1'b0;
    cfg_write3(3, 1024, 0, 1);
    run3 = 1'b1;
    tick(); exp_out3("c3.s0", 0, 0);
    tick(); exp_out3("c3.s1", 1, 0);
    tick(); exp_out3("c3.s2", 2, 0);
    tick(); exp_out3("c3.s3", 0, 0);
    tick(); exp_out3("c3.s4", 1, 0);
    tick(); exp_out3("c3.s5", 2, 0);
    run3 = 1'b0;
    cfg_write3(0, 1024, 0, 1);
    run3 = 1'b1;
    tick(); exp_out3("c3.w0", 0, 1);
    run3 = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
